// File: rtl/count_free_driver.sv
// Initiator for the count_free serial request protocol: it serialises a command, measures response latency, then releases the responder.
// Define CFD_TIMEOUT_EN to enable the WAIT_RSP watchdog (TIMEOUT_CYC); without it, timeout_o is constant 0.
module count_free_driver #(
  parameter int WIDTH       = 32,
  parameter int BIT_DIV     = 20,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             cmd_ready_o,
  output logic             start_req_o,
  output logic             start_data_o,
  input  logic             result_rsp_i,
  input  logic             busy_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [CNT_W-1:0] lat_o,
  output logic             timeout_o
);

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam int DV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(WIDTH);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [DV_W-1:0]  DIV_LAST = DV_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef CFD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_REL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] lat_out_q, lat_out_d;
  logic             req_q, req_d, data_q, data_d, rdy_q, rdy_d;
  logic             done_q, done_d, tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    lat_d     = lat_q;
    lat_out_d = lat_out_q;
    req_d     = req_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: if (cmd_valid_i) begin
          shreg_d   = cmd_data_i;
          bit_cnt_d = BC_FULL;
          div_d     = '0;
          state_d   = S_SEND;
        end
        S_SEND: if (div_q == DIV_LAST) begin
          div_d     = '0;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == BC_ONE) state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
        S_GAP: if (div_q == DIV_LAST) begin
          div_d   = '0;
          lat_d   = '0;
          state_d = S_WAIT;
        end else begin
          div_d = div_q + 1'b1;
        end
        S_WAIT: if (result_rsp_i) begin
          lat_out_d = lat_q;
          state_d   = S_REL;
        end else if (TMO_EN && (lat_q == TMO_LAST)) begin
          lat_out_d = '1;
          tmo_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_REL;
        end else begin
          lat_d = (&lat_q) ? lat_q : lat_q + 1'b1;
        end
        S_REL: if (!busy_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Outputs are registered from the next state, so the first bit lines up with the rising start_req_o.
      req_d  = (state_d == S_SEND);
      data_d = (state_d == S_SEND) && shreg_d[WIDTH-1];
      rdy_d  = (state_d == S_REL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      lat_q     <= '0;
      lat_out_q <= '0;
      req_q     <= 1'b0;
      data_q    <= 1'b0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      lat_q     <= lat_d;
      lat_out_q <= lat_out_d;
      req_q     <= req_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign start_req_o  = req_q;
  assign start_data_o = data_q;
  assign ready_o      = rdy_q;
  assign done_o       = done_q && en;
  assign timeout_o    = tmo_q && en;
  assign lat_o        = lat_out_q;

endmodule

// File: tb/tb_count_free_driver.sv
// Bench for count_free_driver: table rows, hand sequences and random transactions checked against a transaction-level model.
module tb_count_free_driver;
  localparam int W = 8, DIV = 4, CW = 16, TCYC = 50, WMAX = 120;
`ifdef CFD_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, cmd_valid_i, result_rsp_i, busy_i;
  logic [W-1:0]  cmd_data_i;
  logic          cmd_ready_o, start_req_o, start_data_o, ready_o, done_o, timeout_o;
  logic [CW-1:0] lat_o;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [7:0] word; int req_len; int rdy_at; bit tmo; logic [15:0] lat; int rdy_len;
  } exp_t;
  typedef struct {
    logic [7:0] cmd; int rsp; int rel; int en_at; int en_len; exp_t x;
  } vec_t;
  typedef struct {
    logic [7:0] word; int req_len; bit gap_ok; bit first_ok; int rdy_at; bit tmo;
    bit done_rdy; logic [15:0] lat; int rdy_len; bit done_end; bit stray;
  } res_t;

  count_free_driver #(.WIDTH(W), .BIT_DIV(DIV), .CNT_W(CW), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid_i(cmd_valid_i), .cmd_data_i(cmd_data_i),
    .cmd_ready_o(cmd_ready_o), .start_req_o(start_req_o), .start_data_o(start_data_o),
    .result_rsp_i(result_rsp_i), .busy_i(busy_i), .ready_o(ready_o), .done_o(done_o),
    .lat_o(lat_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".cmd_ready"}, cmd_ready_o, 1);
    chk({nm, ".req"}, start_req_o, 0);
    chk({nm, ".data"}, start_data_o, 0);
    chk({nm, ".ready"}, ready_o, 0);
    chk({nm, ".done"}, done_o, 0);
    chk({nm, ".timeout"}, timeout_o, 0);
    chk({nm, ".lat"}, lat_o, 0);
  endtask

  // Transaction-level expectation straight from the protocol rules.
  function automatic exp_t model(input logic [7:0] cmd, input int rsp, input int rel, input int en_len);
    exp_t x;
    x.word = cmd; x.req_len = W * DIV + en_len; x.rdy_len = rel;
    if (TMO_ON && rsp >= TCYC) begin
      x.rdy_at = TCYC; x.tmo = 1'b1; x.lat = 16'hFFFF;
    end else if (rsp + 1 >= WMAX) begin
      x.rdy_at = -1; x.tmo = 1'b0; x.lat = 16'h0;
    end else begin
      x.rdy_at = rsp + 1; x.tmo = 1'b0; x.lat = 16'(rsp);
    end
    return x;
  endfunction

  // Called at a negedge; returns at the done negedge (or after WMAX wait cycles with no release).
  task automatic run_txn(input logic [7:0] cmd, input int rsp, input int rel, input int en_at,
                         input int en_len, input bit hold, input logic [7:0] nxt, output res_t r);
    int w, i, e, cnt;
    r = '{default: 0};
    busy_i = 1'b1; result_rsp_i = 1'b0; cmd_valid_i = 1'b1; cmd_data_i = cmd;
    w = 0;
    while (!cmd_ready_o && w < 200) begin @(negedge clk); w++; end
    chk("accept", cmd_ready_o, 1);
    @(negedge clk);
    if (!hold) cmd_valid_i = 1'b0;
    r.first_ok = start_req_o && !cmd_ready_o && !done_o;
    i = 0;
    while (start_req_o && i < 400) begin
      if (en_at < 0 || i <= en_at) e = i;
      else if (i <= en_at + en_len) e = en_at;
      else e = i - en_len;
      if (e % DIV == DIV / 2 && e / DIV < W) r.word[W-1-e/DIV] = start_data_o;
      if (i == en_at) en = 1'b0;
      if (en_at >= 0 && i == en_at + en_len) en = 1'b1;
      @(negedge clk); i++;
    end
    r.req_len = i;
    en = 1'b1;
    r.gap_ok = !start_data_o;
    for (int j = 1; j < DIV; j++) begin
      @(negedge clk);
      if (start_req_o || start_data_o) r.gap_ok = 1'b0;
    end
    r.rdy_at = -1;
    for (int k = 0; k < WMAX; k++) begin
      @(negedge clk);
      if (ready_o) begin
        r.rdy_at = k; r.tmo = timeout_o; r.done_rdy = done_o;
        break;
      end
      if (done_o || timeout_o) r.stray = 1'b1;
      if (k == rsp) result_rsp_i = 1'b1;
    end
    result_rsp_i = 1'b0;
    if (r.rdy_at >= 0) begin
      cnt = 1;
      while (cnt < 50) begin
        if (cnt == rel) busy_i = 1'b0;
        @(negedge clk);
        if (!ready_o) break;
        cnt++;
      end
      r.rdy_len = cnt; r.done_end = done_o; r.lat = lat_o;
      if (hold) cmd_data_i = nxt;
    end
  endtask

  task automatic check_txn(input string nm, input exp_t x, input res_t r);
    chk({nm, ".word"}, r.word, x.word);
    chk({nm, ".req_len"}, r.req_len, x.req_len);
    chk({nm, ".first"}, r.first_ok, 1);
    chk({nm, ".gap"}, r.gap_ok, 1);
    chk({nm, ".stray"}, r.stray, 0);
    chk({nm, ".rdy_at"}, r.rdy_at, x.rdy_at);
    chk({nm, ".tmo"}, r.tmo, x.tmo);
    if (x.rdy_at >= 0) begin
      chk({nm, ".done_rdy"}, r.done_rdy, x.tmo);
      chk({nm, ".rdy_len"}, r.rdy_len, x.rdy_len);
      chk({nm, ".done_end"}, r.done_end, 1);
      chk({nm, ".lat"}, r.lat, x.lat);
    end
  endtask

  initial begin
    vec_t tbl [4];
    res_t r;
    exp_t x;
    int en_at, en_len, rsp, rel;
    logic [7:0] cmd;

    tbl[0] = '{8'hA5, 37, 3, -1, 0, '{8'hA5, 32, 38, 1'b0, 16'd37, 3}};
    tbl[1] = '{8'h3C, 0, 1, -1, 0, '{8'h3C, 32, 1, 1'b0, 16'd0, 1}};
    tbl[2] = '{8'h5A, 5, 2, 9, 10, '{8'h5A, 42, 6, 1'b0, 16'd5, 2}};
    tbl[3] = '{8'h80, 49, 4, -1, 0, '{8'h80, 32, 50, 1'b0, 16'd49, 4}};

    rst = 1'b1; en = 1'b1; cmd_valid_i = 1'b0; cmd_data_i = '0;
    result_rsp_i = 1'b0; busy_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run_txn(tbl[t].cmd, tbl[t].rsp, tbl[t].rel, tbl[t].en_at, tbl[t].en_len, 1'b0, 8'h00, r);
      check_txn($sformatf("tbl%0d", t), tbl[t].x, r);
    end

    // Asynchronous reset in mid-frame abandons it at once.
    cmd_valid_i = 1'b1; cmd_data_i = 8'hF0; busy_i = 1'b1;
    @(negedge clk); cmd_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre.req", start_req_o, 1);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_abandon.req", start_req_o, 0);
    chk("rst_abandon.cmd_ready", cmd_ready_o, 1);

    // cmd_valid_i held through both commands; the second may only go after done_o.
    run_txn(8'h01, 3, 2, -1, 0, 1'b1, 8'hFF, r);
    check_txn("b2b0", model(8'h01, 3, 2, 0), r);
    run_txn(8'hFF, 6, 2, -1, 0, 1'b1, 8'hFF, r);
    cmd_valid_i = 1'b0;
    check_txn("b2b1", model(8'hFF, 6, 2, 0), r);

    for (int n = 0; n < 10; n++) begin
      cmd = 8'($urandom);
      rsp = $urandom_range(45, 0);
      rel = $urandom_range(5, 1);
      if ($urandom_range(1, 0) == 1) begin
        en_at = $urandom_range(30, 0); en_len = $urandom_range(6, 1);
      end else begin
        en_at = -1; en_len = 0;
      end
      run_txn(cmd, rsp, rel, en_at, en_len, 1'b0, 8'h00, r);
      check_txn($sformatf("rnd%0d", n), model(cmd, rsp, rel, en_len), r);
    end

    // Responder never answers: watchdog fires only when the feature is built in.
    x = model(8'hC3, 1000, 2, 0);
    run_txn(8'hC3, 1000, 2, -1, 0, 1'b0, 8'h00, r);
    check_txn("tmo", x, r);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset("tmo_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
